af6cesrtl_gapseg: RTL

Downstream consumer of the gap request buffer. It pops one request at a time from the buffer's `oreq`/`oreqinfo`/`iget` handshake. Each request is a base address plus a word length. The block splits it into bursts that never cross a `BURST`-word aligned boundary and presents them to the memory read engine over a valid/ready command port.

---
 rtl/af6cesrtl_gapseg.sv | 109 ++++++++++
 1 files changed

// File: rtl/af6cesrtl_gapseg.sv
// Gap request segmenter: pops base/length requests from the gap buffer and
// splits them into bursts that never cross a BURST-word aligned boundary.
module af6cesrtl_gapseg #(
    parameter int unsigned INFO  = 32,
    parameter int unsigned LENW  = 8,
    parameter int unsigned BURST = 16,
    parameter int unsigned ADDRW = INFO - LENW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ireq,
    input  logic [INFO-1:0]  ireqinfo,
    output logic             oget,
    output logic             ocmdvld,
    output logic [ADDRW-1:0] ocmdaddr,
    output logic [LENW-1:0]  ocmdlen,
    output logic             ocmdlast,
    input  logic             icmdrdy,
    output logic             ozerolen,
    output logic             oidle
);

    localparam int unsigned BW = $clog2(BURST);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [ADDRW-1:0] curaddr, curaddr_nxt;
    logic [LENW-1:0]  remlen, remlen_nxt;
    logic [1:0]       fhold, fhold_nxt;
    logic [LENW-1:0]  room;
    logic [LENW-1:0]  blen;
    logic             last;
    logic [LENW-1:0]  req_len;
    logic [ADDRW-1:0] req_addr;

    assign req_len  = ireqinfo[LENW-1:0];
    assign req_addr = ireqinfo[INFO-1:LENW];

    // Words left before the next aligned BURST boundary.
    assign room = LENW'(BURST) - LENW'(curaddr[BW-1:0]);
    assign blen = (remlen < room) ? remlen : room;
    assign last = (remlen <= room);

    assign ocmdaddr = curaddr;
    assign ocmdlen  = blen;
    assign ocmdlast = last;
    assign oidle    = (state == S_IDLE) && (fhold == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            curaddr <= '0;
            remlen  <= '0;
            fhold   <= 2'b11;
        end else begin
            state   <= state_nxt;
            curaddr <= curaddr_nxt;
            remlen  <= remlen_nxt;
            fhold   <= fhold_nxt;
        end
    end

    // Flush overrides everything; holdoff masks the buffer's delayed flush.
    always_comb begin
        state_nxt   = state;
        curaddr_nxt = curaddr;
        remlen_nxt  = remlen;
        fhold_nxt   = flush ? 2'b11 : {1'b0, fhold[1]};
        oget        = 1'b0;
        ocmdvld     = 1'b0;
        ozerolen    = 1'b0;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ireq && (fhold == 2'b00)) begin
                        oget        = 1'b1;
                        curaddr_nxt = req_addr;
                        remlen_nxt  = req_len;
                        state_nxt   = (req_len == '0) ? S_DROP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ocmdvld = 1'b1;
                    if (icmdrdy) begin
                        curaddr_nxt = curaddr + ADDRW'(blen);
                        remlen_nxt  = remlen - blen;
                        if (last) begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    ozerolen  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule
